// File: rtl/pixel_packer_pkg.sv
// Shared definitions for the pixel packer: active-level constants and the
// frame-level state encoding.
package pixel_packer_pkg;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_packer_if.sv
// Pixel stream in, packed-word write port out. The master side feeds pixels
// and owns buf_rdy; the slave side is the packer.
interface pixel_packer_if #(
  parameter int PIX_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
);

  logic                  frame_start;
  logic                  pix_valid;
  logic [PIX_WIDTH-1:0]  pix_data;
  logic                  buf_rdy;
  logic                  wr_en_out;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output frame_start, pix_valid, pix_data, buf_rdy,
    input  wr_en_out, data_out
  );

  modport slave (
    input  frame_start, pix_valid, pix_data, buf_rdy,
    output wr_en_out, data_out
  );

endinterface

// File: rtl/pixel_packer_hold.sv
// Single-entry hold register between the packer and the frame buffer write
// port: loads completed words, hands them off, and flags dropped words.
module pix_out_hold
  import pixel_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  rdy,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  overflow,
  output logic                  full
);

  logic consume;

  assign full    = (wr_en == ASSERT_L);
  assign consume = full && rdy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en    <= DEASSERT_L;
      data     <= '0;
      overflow <= DEASSERT_H;
    end else begin
      if (load && (!full || consume)) begin
        wr_en <= ASSERT_L;
        data  <= load_data;
      end else if (consume) begin
        wr_en <= DEASSERT_L;
      end
      // A word arriving while the slot is occupied and not draining is lost;
      // the held word keeps priority.
      if (load && full && !consume) begin
        overflow <= ASSERT_H;
      end
    end
  end

endmodule

// File: rtl/pixel_packer.sv
// Packs PIX_WIDTH-bit camera pixels little-endian into DATA_WIDTH-bit words,
// counts words per frame and drains the last word before reporting frame_done.
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter int PIX_WIDTH   = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int FRAME_WORDS = 500,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pixel_packer_if.slave        bus,
  output logic                 frame_done,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 busy
);

  localparam int PIX_PER_WORD = DATA_WIDTH / PIX_WIDTH;
  localparam int IDX_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(PIX_PER_WORD - 1);
  localparam logic [CNT_WIDTH-1:0] FRAME_CNT = CNT_WIDTH'(FRAME_WORDS);

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      eff_idx;
  logic [DATA_WIDTH-1:0] word_reg;
  logic [DATA_WIDTH-1:0] assembled;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic                  start_ok;
  logic                  accept;
  logic                  complete;
  logic                  hold_full;

  // NOTE: every always_comb output gets a default before any conditional
  // update, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    start_ok  = bus.frame_start && (state != DRAIN);
    accept    = bus.pix_valid && (start_ok || (state == PACK));
    eff_idx   = start_ok ? '0 : idx;
    complete  = accept && (eff_idx == LAST_IDX);
    assembled = word_reg;
    assembled[eff_idx*PIX_WIDTH +: PIX_WIDTH] = bus.pix_data;
    cnt_next  = start_ok ? '0 : word_count;
    if (complete && (cnt_next != FRAME_CNT)) begin
      cnt_next = cnt_next + 1'b1;
    end
  end

  // Stale pixels from an abandoned partial word are overwritten slot by slot
  // before the next completion, so a restart only needs to rewind idx.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      word_reg   <= '0;
      word_count <= '0;
      frame_done <= DEASSERT_H;
      busy       <= DEASSERT_H;
    end else begin
      frame_done <= DEASSERT_H;
      word_count <= cnt_next;
      if (accept) begin
        word_reg <= assembled;
        idx      <= complete ? '0 : eff_idx + 1'b1;
      end else if (start_ok) begin
        idx <= '0;
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            state <= (cnt_next == FRAME_CNT) ? DRAIN : PACK;
            busy  <= ASSERT_H;
          end
        end
        PACK: begin
          if (cnt_next == FRAME_CNT) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!hold_full) begin
            state      <= IDLE;
            busy       <= DEASSERT_H;
            frame_done <= ASSERT_H;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= DEASSERT_H;
        end
      endcase
    end
  end

  pix_out_hold #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (complete),
    .load_data (assembled),
    .rdy       (bus.buf_rdy),
    .wr_en     (bus.wr_en_out),
    .data      (bus.data_out),
    .overflow  (overflow),
    .full      (hold_full)
  );

endmodule

// File: tb/tb_pixel_packer.sv
// Scoreboard bench for pixel_packer: a frame-level model pushes expected words,
// a negedge monitor pops them whenever the buffer consumes a word.
module tb_pixel_packer;

  localparam int PW  = 8;
  localparam int DW  = 32;
  localparam int FW  = 4;
  localparam int CW  = 16;
  localparam int PPW = DW / PW;

  logic clk = 1'b0;
  logic reset;
  logic frame_done, overflow, busy;
  logic [CW-1:0] word_count;

  always #5 clk = ~clk;

  pixel_packer_if #(.PIX_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

  pixel_packer #(
    .PIX_WIDTH   (PW),
    .DATA_WIDTH  (DW),
    .FRAME_WORDS (FW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .frame_done (frame_done),
    .overflow   (overflow),
    .word_count (word_count),
    .busy       (busy)
  );

  typedef enum {M_IDLE, M_PACK, M_DRAIN} mphase_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_writes = 0;
  int            n_done   = 0;
  logic [DW-1:0] exp_q[$];
  logic [PW-1:0] m_pix[$];
  mphase_t       m_phase  = M_IDLE;
  int            m_words  = 0;
  bit            m_ovf    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pack_word(input logic [PW-1:0] p[$]);
    logic [DW-1:0] w = '0;
    for (int k = 0; k < PPW; k++) w = w | (DW'(p[k]) << (PW * k));
    return w;
  endfunction

  // Frame-level model: pixels collect in a list until a word is full; a word
  // reaches the buffer only if nothing is waiting there (exp_q mirrors the slot).
  task automatic model_edge(input bit fs, input bit pv, input logic [PW-1:0] pd);
    if (fs && m_phase != M_DRAIN) begin
      m_phase = M_PACK;
      m_words = 0;
      m_pix.delete();
    end
    if (pv && m_phase == M_PACK) begin
      m_pix.push_back(pd);
      if (m_pix.size() == PPW) begin
        if (exp_q.size() == 0) exp_q.push_back(pack_word(m_pix));
        else m_ovf = 1'b1;
        m_pix.delete();
        m_words++;
        if (m_words == FW) m_phase = M_DRAIN;
      end
    end
  endtask

  task automatic step(input bit fs, input bit pv, input logic [PW-1:0] pd,
                      input bit rdy, input bit rst = 1'b0);
    reset           = rst;
    bus.frame_start = fs;
    bus.pix_valid   = pv;
    bus.pix_data    = pd;
    bus.buf_rdy     = rdy;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_pix.delete();
      m_phase = M_IDLE;
      m_words = 0;
      m_ovf   = 1'b0;
    end else begin
      model_edge(fs, pv, pd);
    end
    #1;
    if (m_phase == M_DRAIN && frame_done === 1'b1) begin
      check("drained_at_done", exp_q.size(), 0);
      m_phase = M_IDLE;
      n_done++;
    end else begin
      check("frame_done", frame_done, 0);
    end
    check("word_count", word_count, m_words);
    check("overflow", overflow, m_ovf);
    check("busy", busy, m_phase != M_IDLE);
    check("wr_en_out", bus.wr_en_out, exp_q.size() == 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && m_phase != M_IDLE; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
    if (m_phase != M_IDLE) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: frame_done not seen within 50 cycles");
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.wr_en_out === 1'b0 && bus.buf_rdy === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got %h expected no write", bus.data_out);
      end else begin
        check("data_out", bus.data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int w0;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = '0;
    bus.buf_rdy     = 1'b0;
    reset           = 1'b1;
    @(posedge clk);
    #1;

    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("reset_data_out", bus.data_out, 0);

    // Pixels in IDLE without frame_start are ignored
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'($urandom), 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end

    // First word of a frame
    step(1'b1, 1'b1, 8'h11, 1'b1);
    step(1'b0, 1'b1, 8'h22, 1'b1);
    step(1'b0, 1'b1, 8'h33, 1'b1);
    step(1'b0, 1'b1, 8'h44, 1'b1);
    check("t1_data", bus.data_out, 32'h4433_2211);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Full frame, then a stray pixel afterwards
    d0 = n_done;
    w0 = n_writes;
    step(1'b1, 1'b1, 8'h00, 1'b1);
    for (int i = 1; i < 16; i++) step(1'b0, 1'b1, 8'(i), 1'b1);
    wait_idle();
    check("t2_done_count", n_done - d0, 1);
    check("t2_writes", n_writes - w0, 4);
    step(1'b0, 1'b1, 8'h10, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Stalled buffer: second word dropped, first kept
    w0 = n_writes;
    step(1'b1, 1'b1, 8'h00, 1'b0);
    for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    check("t3_held", bus.data_out, 32'h0302_0100);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("t3_writes", n_writes - w0, 1);
    for (int i = 8; i < 12; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    // Reset while a write is pending clears everything
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("t5_wr_en", bus.wr_en_out, 1);

    // Restart mid-frame; earlier word still delivered
    step(1'b1, 1'b1, 8'h00, 1'b0);
    for (int i = 1; i < 6; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    step(1'b1, 1'b1, 8'hA0, 1'b1);
    step(1'b0, 1'b1, 8'hA1, 1'b1);
    step(1'b0, 1'b1, 8'hA2, 1'b1);
    step(1'b0, 1'b1, 8'hA3, 1'b0);
    check("t4_data", bus.data_out, 32'hA3A2_A1A0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // frame_start and pixels during DRAIN are ignored
    step(1'b1, 1'b1, 8'h00, 1'b0);
    for (int i = 1; i < 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
    wait_idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized frames with random stalls, restarts and rare resets
    for (int f = 0; f < 40; f++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
      for (int c = 0; c < 300 && m_phase == M_PACK; c++) begin
        if ($urandom_range(0, 199) == 0)
          step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        else
          step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0),
               8'($urandom), 1'($urandom_range(0, 3) != 0));
      end
      wait_idle();
    end

    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_packer.md
Name: pixel_packer

Overview:
Upstream feeder for the frame buffer write port. It collects a stream of narrow camera pixels and packs them into DATA_WIDTH-bit words. Each packed word is presented with an active-low write request that connects directly to the buffer's wr_en_in/data_in. The block counts words per frame, signals frame completion and flags dropped words.

Parameters:
PIX_WIDTH, 8, bits per input pixel.
DATA_WIDTH, 32, output word width; must be an integer multiple of PIX_WIDTH.
PIX_PER_WORD, DATA_WIDTH/PIX_WIDTH, pixels per packed word (derived; do not override).
FRAME_WORDS, 500, words per frame; must be >= 1.
CNT_WIDTH, 16, width of word_count; must satisfy 2^CNT_WIDTH > FRAME_WORDS.

Ports:
clk  in  1  single clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
frame_start  in  1  one-cycle pulse marking the first pixel of a frame.
pix_valid  in  1  pix_data valid this cycle.
pix_data  in  PIX_WIDTH  pixel value.
buf_rdy  in  1  high when the downstream buffer accepts a word this edge.
wr_en_out  out  1  active-low write request to the buffer (ASSERT_L = word valid).
data_out  out  DATA_WIDTH  packed word; stable while wr_en_out is asserted.
frame_done  out  1  one-cycle pulse when a frame has fully drained.
overflow  out  1  sticky; set when a completed word is dropped.
word_count  out  CNT_WIDTH  words completed in the current frame.
busy  out  1  high in PACK or DRAIN.

Behaviour:
- Reset values: wr_en_out=1 (deasserted), data_out=0, frame_done=0, overflow=0, word_count=0, busy=0; state IDLE; pack index=0; hold register empty.
- Reset mid-operation drops the partial word and any held word. No write is issued afterwards.
- States: IDLE, PACK, DRAIN.
- IDLE:
  - pix_valid without frame_start is ignored.
  - frame_start -> PACK. If pix_valid is high in the same cycle, that pixel is pixel 0 of the frame.
- Packing order: little-endian. Pixel k of a word goes to bits [(k+1)*PIX_WIDTH-1 : k*PIX_WIDTH].
- Pack index increments on each accepted pixel and wraps at PIX_PER_WORD.
- Word completion:
  - Occurs when the pixel at index PIX_PER_WORD-1 is accepted.
  - The word loads into the hold register; wr_en_out goes low on the next cycle (latency 1).
  - word_count increments on the completing edge.
- Hand-off:
  - A word is consumed on an edge where wr_en_out=0 and buf_rdy=1.
  - wr_en_out returns high the next cycle unless a new word loads on the same edge.
  - Back-to-back loads give continuous low with new data each cycle.
- Collision: a word completes while the hold register is full and is not being consumed this edge.
  - The new word is dropped and overflow is set.
  - The held word is preserved.
  - word_count still increments.
- PACK -> DRAIN when word_count reaches FRAME_WORDS. Pixels arriving in DRAIN or IDLE are ignored.
- DRAIN -> IDLE once the hold register is empty. frame_done pulses for exactly 1 cycle on entry to IDLE.
- frame_start while in PACK restarts the frame:
  - the partial word is discarded and pack index resets to 0;
  - word_count is cleared;
  - the held word is still delivered;
  - overflow is unchanged.
- frame_start while in DRAIN is ignored.
- overflow clears only on reset.
- Width rule: word_count saturates at FRAME_WORDS and never wraps.

Decomposition:
- Shared package: ASSERT_L/DEASSERT_L and ASSERT_H/DEASSERT_H constants (existing shared definitions), and the IDLE/PACK/DRAIN state encoding.
- One natural sub-module: pix_out_hold, the single-entry hold register with load, consume and collision logic.
- Packing shift logic and the FSM stay in pixel_packer.

Test Plan:
Use PIX_WIDTH=8, DATA_WIDTH=32, FRAME_WORDS=4 unless noted.
1. reset, frame_start with pix 0x11,0x22,0x33,0x44 on consecutive cycles, buf_rdy=1 -> cycle after 0x44: wr_en_out=0 for 1 cycle, data_out=0x44332211, word_count=1.
2. Frame of 16 pixels 0x00..0x0F, buf_rdy=1 -> words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; frame_done pulses once after last consume; busy=0; pixel 0x10 afterwards ignored.
3. buf_rdy=0, 8 pixels 0x00..0x07 -> data_out holds 0x03020100, overflow=1 at 2nd completion; buf_rdy=1 -> one write of 0x03020100 only.
4. 6 pixels then frame_start with pix 0xA0, followed by 0xA1..0xA3 -> word_count reset then 1, data_out=0xA3A2A1A0; 1st word 0x03020100 still written.
5. reset asserted while wr_en_out=0 -> next cycle wr_en_out=1, overflow=0, word_count=0, busy=0.
6. pix_valid pulses in IDLE without frame_start -> wr_en_out stays 1, word_count stays 0.
